// File: rtl/mtimer_irq.sv
`default_nettype none
// mtimer_irq: memory-mapped RISC-V machine timer (64-bit mtime/mtimecmp) driving a
// registered, level-sensitive machine-timer interrupt; single-cycle register bus.
module mtimer_irq #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              write_i,
  input  logic              read_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              irq_o,
  output logic [63:0]       mtime_o
);

  localparam logic [2:0]  OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0]  OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0]  OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0]  OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0]  OFF_CTRL        = 3'd4;
  localparam logic [2:0]  OFF_STATUS      = 3'd5;
  localparam logic [15:0] PRESCALE_LAST   = 16'(PRESCALE - 1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] presc;
  logic        en;
  logic        ie;
  logic [31:0] hi_shadow;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  logic [2:0]  word;
  logic        tick;
  logic        pending;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_ctrl;
  logic        rd_mtime_lo;
  logic [31:0] rd_mux;

  assign word        = addr_i[4:2];
  assign tick        = en && (presc == PRESCALE_LAST);
  assign pending     = (mtime >= mtimecmp);

  assign wr_mtime_lo = write_i && (word == OFF_MTIME_LO);
  assign wr_mtime_hi = write_i && (word == OFF_MTIME_HI);
  assign wr_cmp_lo   = write_i && (word == OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = write_i && (word == OFF_MTIMECMP_HI);
  assign wr_ctrl     = write_i && (word == OFF_CTRL);
  assign rd_mtime_lo = read_i  && (word == OFF_MTIME_LO);

  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_i[1:0];

  generate
    if (ADDR_W > 5) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_i[ADDR_W-1:5];
    end
  endgenerate

  // Software writes to mtime win over the tick and restart the prescaler period,
  // so a written value is never bumped or carried into on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime <= '0;
      presc <= '0;
    end else if (wr_mtime_lo || wr_mtime_hi) begin
      presc <= '0;
      if (wr_mtime_lo) mtime[31:0]  <= wdata_i;
      if (wr_mtime_hi) mtime[63:32] <= wdata_i;
    end else if (en) begin
      if (tick) begin
        presc <= '0;
        mtime <= mtime + 64'd1;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp <= '1;
      en       <= 1'b0;
      ie       <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= wdata_i;
      if (wr_cmp_hi) mtimecmp[63:32] <= wdata_i;
      if (wr_ctrl) begin
        en <= wdata_i[0];
        ie <= wdata_i[1];
      end
    end
  end

  // Reads sample pre-edge state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_mux = 32'd0;
    case (word)
      OFF_MTIME_LO:    rd_mux = mtime[31:0];
      OFF_MTIME_HI:    rd_mux = hi_shadow;
      OFF_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      OFF_CTRL:        rd_mux = {30'd0, ie, en};
      OFF_STATUS:      rd_mux = {31'd0, pending};
      default:         rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      hi_shadow <= '0;
    end else begin
      rvalid <= read_i;
      if (read_i) rdata <= rd_mux;
      if (rd_mtime_lo) hi_shadow <= mtime[63:32];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq <= 1'b0;
    else       irq <= ie && pending;
  end

  assign rdata_o  = rdata;
  assign rvalid_o = rvalid;
  assign irq_o    = irq;
  assign mtime_o  = mtime;

endmodule
`default_nettype wire

// File: tb/tb_mtimer_irq.sv
`default_nettype none
// tb_mtimer_irq: directed bench; read responses are checked by a queue-based monitor.
module tb_mtimer_irq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst4;
  logic [4:0]  addr1, addr4;
  logic [31:0] wdata1, wdata4;
  logic        write1, write4, read1, read4;
  logic [31:0] rdata1, rdata4;
  logic        rvalid1, rvalid4, irq1, irq4;
  logic [63:0] mtime1, mtime4;

  mtimer_irq #(.PRESCALE(1), .ADDR_W(5)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .addr_i(addr1), .wdata_i(wdata1),
    .write_i(write1), .read_i(read1), .rdata_o(rdata1), .rvalid_o(rvalid1),
    .irq_o(irq1), .mtime_o(mtime1)
  );

  mtimer_irq #(.PRESCALE(4), .ADDR_W(5)) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .addr_i(addr4), .wdata_i(wdata4),
    .write_i(write4), .read_i(read4), .rdata_o(rdata4), .rvalid_o(rvalid4),
    .irq_o(irq4), .mtime_o(mtime4)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_data_q[$];
  string       exp_name_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input logic [63:0] act,
                           input logic [63:0] lo, input logic [63:0] hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rvalid1) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %h expected no response", rdata1);
      end else begin
        automatic logic [31:0] e = exp_data_q.pop_front();
        automatic string       n = exp_name_q.pop_front();
        if (rdata1 !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, rdata1, e);
        end
      end
    end
  end

  // Bus tasks are entered at a falling edge and return at the next falling edge.
  task automatic wr1(input logic [2:0] w, input logic [31:0] d);
    addr1 = {w, 2'b00}; wdata1 = d; write1 = 1'b1;
    @(negedge clk);
    write1 = 1'b0;
  endtask

  task automatic rd1(input logic [2:0] w, input logic [31:0] exp, input string name);
    addr1 = {w, 2'b01}; read1 = 1'b1;
    exp_data_q.push_back(exp);
    exp_name_q.push_back(name);
    @(negedge clk);
    read1 = 1'b0;
  endtask

  task automatic rw1(input logic [2:0] w, input logic [31:0] d, input logic [31:0] exp,
                     input string name);
    addr1 = {w, 2'b00}; wdata1 = d; write1 = 1'b1; read1 = 1'b1;
    exp_data_q.push_back(exp);
    exp_name_q.push_back(name);
    @(negedge clk);
    write1 = 1'b0; read1 = 1'b0;
  endtask

  task automatic wr4(input logic [2:0] w, input logic [31:0] d);
    addr4 = {w, 2'b00}; wdata4 = d; write4 = 1'b1;
    @(negedge clk);
    write4 = 1'b0;
  endtask

  task automatic wait_mtime1(input logic [63:0] target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (mtime1 == target) break;
      @(negedge clk);
    end
  endtask

  logic [63:0] frozen;

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    addr1 = '0; wdata1 = '0; write1 = 1'b0; read1 = 1'b0;
    addr4 = '0; wdata4 = '0; write4 = 1'b0; read4 = 1'b0;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst4 = 1'b0;

    chk("reset_mtime", mtime1, 64'd0);
    chk("reset_irq", {63'd0, irq1}, 64'd0);
    chk("reset_rvalid", {63'd0, rvalid1}, 64'd0);
    chk("reset_rdata", {32'd0, rdata1}, 64'd0);

    // Asynchronous reset in the middle of a count
    wr1(3'd4, 32'd1);
    wait_mtime1(64'd37, 100);
    chk("reach_37", mtime1, 64'd37);
    #1 rst1 = 1'b1;
    #1;
    chk("async_rst_mtime", mtime1, 64'd0);
    chk("async_rst_irq", {63'd0, irq1}, 64'd0);
    chk("async_rst_rvalid", {63'd0, rvalid1}, 64'd0);
    @(negedge clk);
    rst1 = 1'b0;
    rd1(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd1(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd1(3'd4, 32'd0, "rst_ctrl");
    rd1(3'd0, 32'd0, "rst_mtime_lo");

    // Prescaled counting and freeze
    wr4(3'd4, 32'd1);
    repeat (39) @(negedge clk);
    chk_range("presc4_count", mtime4, 64'd9, 64'd11);
    wr4(3'd4, 32'd0);
    frozen = mtime4;
    repeat (20) @(negedge clk);
    chk("presc4_frozen", mtime4, frozen);

    // Interrupt assert and clear
    wr1(3'd3, 32'd0);
    wr1(3'd2, 32'd20);
    wr1(3'd4, 32'd3);
    wait_mtime1(64'd20, 100);
    chk("reach_20", mtime1, 64'd20);
    chk("irq_not_yet", {63'd0, irq1}, 64'd0);
    @(negedge clk);
    chk("irq_rise", {63'd0, irq1}, 64'd1);
    wr1(3'd2, 32'd1000);
    chk("irq_hold_at_write", {63'd0, irq1}, 64'd1);
    @(negedge clk);
    chk("irq_fall", {63'd0, irq1}, 64'd0);
    rd1(3'd5, 32'd0, "status_clear");

    // IE gating
    wr1(3'd4, 32'd1);
    wr1(3'd2, 32'd5);
    repeat (2) @(negedge clk);
    chk("irq_gated", {63'd0, irq1}, 64'd0);
    rd1(3'd5, 32'd1, "status_raw");
    wr1(3'd4, 32'd3);
    chk("irq_ie_edge", {63'd0, irq1}, 64'd0);
    @(negedge clk);
    chk("irq_ie_on", {63'd0, irq1}, 64'd1);

    // Carry into the high word and atomic 64-bit read
    wr1(3'd4, 32'd0);
    wr1(3'd0, 32'hFFFF_FFFE);
    wr1(3'd1, 32'd0);
    wr1(3'd4, 32'd1);
    chk("carry_start", mtime1, 64'h0000_0000_FFFF_FFFE);
    @(negedge clk);
    rd1(3'd0, 32'hFFFF_FFFF, "atomic_lo");
    chk("carry_done", mtime1, 64'h0000_0001_0000_0000);
    @(negedge clk);
    chk("live_hi", {32'd0, mtime1[63:32]}, 64'd1);
    rd1(3'd1, 32'd0, "atomic_hi_shadow");

    // Write colliding with a tick
    wr1(3'd0, 32'd5);
    chk("collide_write", mtime1, 64'h0000_0001_0000_0005);
    @(negedge clk);
    chk("collide_next", mtime1, 64'h0000_0001_0000_0006);
    rd1(3'd7, 32'd0, "unmapped_7");

    // Read/write same register in one cycle returns the old value
    rw1(3'd4, 32'hFFFF_FFFF, 32'd1, "rw_pre_write");
    rd1(3'd4, 32'd3, "ctrl_masked");

    repeat (3) @(negedge clk);
    chk("responses_drained", 64'(exp_data_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mtimer_irq.md
Name: mtimer_irq

Overview:
- Memory-mapped RISC-V machine timer. Holds a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register.
- Produces the level-sensitive machine-timer interrupt `irq_o`, which feeds the `irq_i` input of the `csr` unit.
- It is the interrupt-source end of the CSR interrupt interface. The core's load/store path accesses it over a simple single-cycle register bus.

Parameters:
- PRESCALE, 1, clock cycles per `mtime` increment (valid range 1..65535).
- ADDR_W, 5, width of the byte address input.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- addr_i  input  ADDR_W  byte address; word select is `addr_i[4:2]`, `addr_i[1:0]` is ignored.
- wdata_i  input  32  write data.
- write_i  input  1  write strobe, one access per cycle.
- read_i  input  1  read strobe.
- rdata_o  output  32  registered read data.
- rvalid_o  output  1  `rdata_o` valid; high for exactly one cycle.
- irq_o  output  1  timer interrupt request to `csr.irq_i`.
- mtime_o  output  64  current `mtime`, for debug and trace.

Behaviour:
- Register map (word offset: name, access, reset value):
  - 0: MTIME_LO, RW, 0.
  - 1: MTIME_HI, RW, 0.
  - 2: MTIMECMP_LO, RW, 32'hFFFFFFFF.
  - 3: MTIMECMP_HI, RW, 32'hFFFFFFFF.
  - 4: CTRL, RW, 0. bit0 = EN (count enable), bit1 = IE (irq enable), other bits read 0.
  - 5: STATUS, RO, bit0 = raw pending (`mtime >= mtimecmp`, unsigned 64-bit compare); writes ignored.
  - 6–7: unmapped; reads return 0, writes ignored.
- Reset values: all registers as above, prescaler count 0, HI shadow 0; `rdata_o` = 0, `rvalid_o` = 0, `irq_o` = 0.
- Reset is asynchronous and may be asserted mid-count; all state returns to reset values immediately.
- Prescaler:
  - While EN = 1, the prescaler counts 0..PRESCALE-1.
  - On the cycle it equals PRESCALE-1 it wraps to 0 and `mtime` increments by 1.
  - With PRESCALE = 1, `mtime` increments every cycle.
  - EN = 0 freezes both `mtime` and the prescaler; they are not cleared.
- Wrap-around: `mtime` 64'hFFFF_FFFF_FFFF_FFFF + 1 = 0, with no flag.
- Writes take effect at the clock edge; the new value is visible from the next cycle.
- A write to MTIME_LO or MTIME_HI in the same cycle as a tick:
  - The written half takes `wdata_i`; the other half holds its old value (no increment and no carry that cycle).
  - The prescaler resets to 0.
- Reads:
  - `read_i` with `addr_i` captured → `rdata_o` and `rvalid_o` = 1 on the next cycle (latency 1).
  - `rvalid_o` = 0 in every cycle with no read; `rdata_o` holds its last value.
- Atomic 64-bit read:
  - A read of MTIME_LO also latches the current `mtime[63:32]` into the HI shadow.
  - A read of MTIME_HI returns the shadow, not the live value.
- Simultaneous `read_i` and `write_i` to the same register: the read returns the pre-write value.
- Interrupt:
  - `irq_o` is registered: `irq_o <= IE & (mtime >= mtimecmp)`. It therefore follows the compare condition one cycle late.
  - `irq_o` is a level: it stays high until software raises `mtimecmp` above `mtime`, clears IE, or writes `mtime` below `mtimecmp`. It deasserts one cycle after that write.
  - There is no acknowledge input. The `csr` unit's `mret_i` does not clear it.
- Updating a 64-bit compare: software must first write MTIMECMP_HI = FFFFFFFF, then LO, then HI, to avoid a spurious irq. The block does not enforce this ordering.

Test Plan:
- Reset:
  - Assert `rst_i` mid-count at `mtime` = 37 → immediately `mtime_o` = 0, `irq_o` = 0, `rvalid_o` = 0.
  - After release, reading offset 2 returns FFFFFFFF.
- Counting, PRESCALE = 4:
  - Write CTRL = 1, then idle 40 cycles → `mtime_o` = 10 (±1 for the write-cycle alignment).
  - Write CTRL = 0 → `mtime_o` stays constant for 20 cycles.
- Interrupt assert and clear:
  - Set MTIMECMP = {HI = 0, LO = 20}, CTRL = 3, PRESCALE = 1.
  - `irq_o` rises exactly one cycle after `mtime_o` reaches 20.
  - Write MTIMECMP_LO = 1000 → `irq_o` falls one cycle after the write edge; STATUS reads 0.
- IE gating: CTRL = 1 with `mtime` > `mtimecmp` → `irq_o` = 0 while STATUS bit0 = 1. Writing CTRL = 3 → `irq_o` = 1 next cycle.
- Carry and atomic read:
  - Write MTIME_LO = FFFFFFFE, MTIME_HI = 0, then EN = 1.
  - Read LO at value FFFFFFFF, then read HI two cycles later → HI returns 0 (shadow) while `mtime_o[63:32]` = 1.
- Write-vs-tick collision: with PRESCALE = 1 and EN = 1, write MTIME_LO = 5 → next cycle `mtime_o` = 5 (high half unchanged), 6 the cycle after. Reading offset 7 → `rdata_o` = 0 with `rvalid_o` = 1.
